// File: rtl/seven_segment_scanner_if.sv
// Display bus between the scanner and its controller: digit data and controls in,
// multiplexed anode/segment drive and the frame strobe out.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [3:0]              brightness;
    logic [NUM_DIGITS-1:0]   anode_signals;
    logic [6:0]              display_out;
    logic                    dp_out;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, blank_lz, blink_mask, brightness,
        input  anode_signals, display_out, dp_out, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blank_lz, blink_mask, brightness,
        output anode_signals, display_out, dp_out, frame_done
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit common-anode seven-segment scanner with frame-coherent capture,
// leading-zero blanking, per-digit blink and PWM brightness; all outputs registered.
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int BLINK_FRAMES   = 250,
    parameter int HEX_MODE       = 0
) (
    input logic                    clock,
    input logic                    reset,
    seven_segment_scanner_if.slave bus
);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SLOT_W  = $clog2(CLKS_PER_DIGIT);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]  LAST_SLOT  = SLOT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]         DASH       = 7'b1111110;

    logic [SLOT_W-1:0]       slot_cnt;
    logic [3:0]              pwm_cnt;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    shadow_blank_lz;
    logic [NUM_DIGITS-1:0]   shadow_blink_mask;

    logic                    blink_phase;
    logic [FRAME_W-1:0]      frame_cnt;

    logic [NUM_DIGITS-1:0]   anode_q;
    logic [6:0]              display_q;
    logic                    dp_q;
    logic                    frame_done_q;

    logic                    frame_start;
    logic                    slot_wrap;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic                    eff_blank_lz;
    logic [NUM_DIGITS-1:0]   eff_blink_mask;

    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    higher_nonzero;
    logic                    lz_blank;
    logic                    blink_blank;
    logic                    digit_blank;
    logic                    lit;

    logic [NUM_DIGITS-1:0]   anode_next;
    logic [6:0]              display_next;
    logic                    dp_next;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = (HEX_MODE != 0) ? 7'b0001000 : DASH;
            4'hB:    g = (HEX_MODE != 0) ? 7'b1100000 : DASH;
            4'hC:    g = (HEX_MODE != 0) ? 7'b0110001 : DASH;
            4'hD:    g = (HEX_MODE != 0) ? 7'b1000010 : DASH;
            4'hE:    g = (HEX_MODE != 0) ? 7'b0110000 : DASH;
            default: g = (HEX_MODE != 0) ? 7'b0111000 : DASH;
        endcase
        return g;
    endfunction

    assign frame_start = (idx == LAST_IDX) && (slot_cnt == '0);
    assign slot_wrap   = (slot_cnt == LAST_SLOT);
    assign frame_end   = slot_wrap && (idx == '0);

    // The capture cycle itself must already show the new frame's data, so bypass
    // the shadow registers while they are being loaded.
    assign eff_digits     = frame_start ? bus.digits_in  : shadow_digits;
    assign eff_dp         = frame_start ? bus.dp_in      : shadow_dp;
    assign eff_blank_lz   = frame_start ? bus.blank_lz   : shadow_blank_lz;
    assign eff_blink_mask = frame_start ? bus.blink_mask : shadow_blink_mask;

    // Select the scanned digit and look at it plus every more significant nibble.
    always_comb begin
        cur_nibble     = 4'h0;
        cur_dp         = 1'b0;
        cur_blink      = 1'b0;
        higher_nonzero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (IDX_W'(j) == idx) begin
                cur_nibble = eff_digits[4*j +: 4];
                cur_dp     = eff_dp[j];
                cur_blink  = eff_blink_mask[j];
            end
            if ((IDX_W'(j) >= idx) && (eff_digits[4*j +: 4] != 4'h0)) begin
                higher_nonzero = 1'b1;
            end
        end
    end

    assign lz_blank    = eff_blank_lz && (idx != '0) && !higher_nonzero;
    assign blink_blank = blink_phase && cur_blink;
    assign digit_blank = blink_blank || lz_blank;
    assign lit         = !digit_blank && (pwm_cnt <= bus.brightness);

    always_comb begin
        anode_next = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((IDX_W'(j) == idx) && lit) begin
                anode_next[j] = 1'b0;
            end
        end
        display_next = digit_blank ? 7'b1111111 : glyph(cur_nibble);
        dp_next      = digit_blank ? 1'b1 : ~cur_dp;
    end

    // Scan timing: slot counter, per-slot PWM phase and digit index (MSD first).
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt <= '0;
            pwm_cnt  <= 4'h0;
            idx      <= LAST_IDX;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            pwm_cnt  <= 4'h0;
            idx      <= (idx == '0) ? LAST_IDX : idx - IDX_W'(1);
        end else begin
            slot_cnt <= slot_cnt + SLOT_W'(1);
            pwm_cnt  <= pwm_cnt + 4'h1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_digits     <= '0;
            shadow_dp         <= '0;
            shadow_blank_lz   <= 1'b0;
            shadow_blink_mask <= '0;
        end else if (frame_start) begin
            shadow_digits     <= bus.digits_in;
            shadow_dp         <= bus.dp_in;
            shadow_blank_lz   <= bus.blank_lz;
            shadow_blink_mask <= bus.blink_mask;
        end
    end

    // Blink phase flips on the same edge that starts a new frame, so a frame is never split.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            anode_q      <= '1;
            display_q    <= 7'b1111111;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            anode_q      <= anode_next;
            display_q    <= display_next;
            dp_q         <= dp_next;
            frame_done_q <= frame_end;
        end
    end

    assign bus.anode_signals = anode_q;
    assign bus.display_out   = display_q;
    assign bus.dp_out        = dp_q;
    assign bus.frame_done    = frame_done_q;

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised, multiplexed N-digit common-anode seven-segment scanner; successor to the fixed 4-digit minutes/seconds driver.
- Takes packed per-digit nibbles and decimal points, plus display controls.
- Time-multiplexes the digits with frame-coherent input capture, optional hex glyphs, leading-zero blanking, per-digit blink and PWM brightness.
- Sits between the stopwatch/BCD datapath and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- CLKS_PER_DIGIT, 50000, clock cycles per digit slot (1 ms at 50 MHz); must be >= 16.
- BLINK_FRAMES, 250, full scan frames per blink half-period.
- HEX_MODE, 0, 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 show dash.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digits_in  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0 (rightmost).
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_lz  in  1  enable leading-zero blanking.
- blink_mask  in  NUM_DIGITS  digits that blink.
- brightness  in  4  PWM duty; 15 = full on.
- anode_signals  out  NUM_DIGITS  active-low digit enables.
- display_out  out  7  active-low segments; bit6 = a ... bit0 = g.
- dp_out  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse at end of each full scan.

Behaviour:
- Clock and reset: single clock `clock`. `reset` is synchronous and active-high. All state updates on the rising edge.
- Reset values:
  - anode_signals all 1; display_out 7'b1111111; dp_out 1; frame_done 0.
  - slot_cnt 0; pwm_cnt 0; idx NUM_DIGITS-1.
  - Shadow registers 0; blink_phase 0; frame counter 0.
  - A reset asserted mid-frame aborts the scan and returns everything to these values on the next edge.
- Slot counter: slot_cnt counts 0..CLKS_PER_DIGIT-1, then wraps.
  - On wrap, idx decrements (most significant digit scanned first).
  - When idx wraps from 0 to NUM_DIGITS-1, frame_done pulses high for exactly 1 cycle.
- Shadow capture: when idx == NUM_DIGITS-1 and slot_cnt == 0 (the first cycle of every frame, including the first after reset), digits_in, dp_in, blank_lz and blink_mask are copied to shadow registers. Input changes mid-frame never show until the next frame.
- Glyphs (active low, abcdefg):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - dash = 1111110
- Leading-zero blanking: with shadow blank_lz = 1, digit i (i > 0) is blank when its nibble and all higher nibbles are 0. Digit 0 is never blanked by this rule.
- Blink: blink_phase toggles after every BLINK_FRAMES frame_done pulses. While blink_phase = 1, digits with their shadow blink_mask bit set are blank.
- Blank digit: anode deasserted (1), display_out all 1, dp_out 1.
- Brightness: pwm_cnt is a 4-bit free-running counter. It resets to 0 at every slot start. The selected anode is driven low only while pwm_cnt <= brightness. Brightness is sampled live, not shadowed.
- Anode overlap: exactly zero or one anode is low in any cycle. At most one anode bit is 0 at all times.
- Latency: outputs are registered. anode_signals, display_out and dp_out reflect the idx, slot_cnt and pwm_cnt values of the previous cycle (1-cycle latency).
- Segments: display_out and dp_out are valid for the whole slot, independent of PWM. Only the anode gates the light.
- Priority for each digit: reset > blink blank > leading-zero blank > glyph.

Test Plan (NUM_DIGITS=4, CLKS_PER_DIGIT=16, BLINK_FRAMES=2, brightness=15 unless stated):
- Reset, then digits_in=16'h1234, dp_in=4'b0100 -> slots show anode 0111/1011/1101/1110 with segments 1001111, 0010010, 0000110, 1001100 respectively. dp_out = 0 only on anode 1011. frame_done pulses every 64 cycles.
- digits_in=16'h0050, blank_lz=1 -> digit3 and digit2 anodes stay 1 for the whole slot. Digit1 shows 0100100, digit0 shows 0000001. digits_in=0 -> only digit0 lit, showing 0000001.
- HEX_MODE=0 with digits_in=16'hAF09 -> digits 3 and 2 show 1111110. HEX_MODE=1 -> they show 0001000 and 0111000.
- Change digits_in from 16'h1111 to 16'h2222 mid-frame at slot 1 -> remaining slots of that frame still show 1001111; the next frame shows 0010010.
- blink_mask=4'b0001 -> digit0 is lit in frames 0-1, dark in frames 2-3, and lit again in frames 4-5. Other digits are unaffected.
- brightness=3 -> anode low for exactly 4 of 16 cycles per slot. Reset asserted mid-slot -> next edge shows all outputs at reset values, and scanning restarts at digit3.
